// File: rtl/gamepad_multi_receiver.sv
// gamepad_multi_receiver: polls NUM_PADS NES/SNES pads over a shared
// latch/clock pair at a fixed frame rate. Each pad has its own serial
// data line. The receiver presents registered, active-high button
// vectors, a connection flag per pad, and change pulses per pad.

// Per-pad lane: holds the shift capture and the committed outputs for one pad
module gamepad_pad_lane (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        data_bit,
  input  logic        sample_en,
  input  logic [3:0]  sample_idx,
  input  logic        commit_en,
  input  logic        mode_snes,
  output logic [11:0] buttons,
  output logic        connected,
  output logic        changed
);

  logic [15:0] raw_q;
  logic [11:0] pressed;
  logic [11:0] btn_nx;
  logic        conn_nx;

  // Capture one serial bit at the end of each high clock phase
  always_ff @(posedge clk_50) begin
    if (reset)          raw_q <= '0;
    else if (sample_en) raw_q[sample_idx] <= data_bit;
  end

  // Decode the raw frame: lines are active-low; an all-pressed frame means
  // nothing is driving the line, and SNES pads always send 1s in bits 12..15
  always_comb begin
    pressed = ~raw_q[11:0];
    if (!mode_snes) pressed[11:8] = 4'b0;
    if (mode_snes) conn_nx = (&raw_q[15:12]) && (|raw_q[11:0]);
    else           conn_nx = |raw_q[7:0];
    btn_nx = conn_nx ? pressed : 12'h000;
  end

  // Commit outputs on the frame's DONE cycle; change flag is a single pulse
  always_ff @(posedge clk_50) begin
    if (reset) begin
      buttons   <= '0;
      connected <= 1'b0;
      changed   <= 1'b0;
    end else begin
      changed <= 1'b0;
      if (commit_en) begin
        buttons   <= btn_nx;
        connected <= conn_nx;
        changed   <= (btn_nx != buttons);
      end
    end
  end

endmodule

module gamepad_multi_receiver #(
  parameter int NUM_PADS  = 2,
  parameter int HALF_CYC  = 300,
  parameter int LATCH_CYC = 600,
  parameter int POLL_CYC  = 833333
) (
  input  logic                    clk_50,
  input  logic                    reset,
  input  logic [NUM_PADS-1:0]     data,
  input  logic                    is_snes,
  output logic                    controller_latch,
  output logic                    controller_clk,
  output logic [NUM_PADS*12-1:0]  buttons,
  output logic [NUM_PADS-1:0]     connected,
  output logic [NUM_PADS-1:0]     changed,
  output logic                    valid
);

  localparam int PW   = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
  localparam int CMAX = (LATCH_CYC > HALF_CYC) ? LATCH_CYC : HALF_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_LATCH, ST_BIT_HI, ST_BIT_LO, ST_DONE
  } state_t;

  state_t        state, state_nx;
  logic [PW-1:0] poll_cnt;
  logic [CW-1:0] phase_cnt;
  logic [3:0]    bit_idx;
  logic [3:0]    bit_last;
  logic          mode_q;
  logic          frame_start;
  logic          latch_end;
  logic          half_end;
  logic          sample_en;
  logic          commit_en;
  logic          latch_nx, clk_nx, valid_nx;

  logic [NUM_PADS-1:0][11:0] btn_lane;

  assign frame_start = (state == ST_IDLE) && (poll_cnt == '0);
  assign latch_end   = (phase_cnt == CW'(LATCH_CYC - 1));
  assign half_end    = (phase_cnt == CW'(HALF_CYC - 1));
  assign bit_last    = mode_q ? 4'd15 : 4'd7;
  assign sample_en   = (state == ST_BIT_HI) && half_end;
  assign commit_en   = (state_nx == ST_DONE);

  // Free-running frame-rate counter; a frame starts whenever it reads zero
  always_ff @(posedge clk_50) begin
    if (reset)                                poll_cnt <= '0;
    else if (poll_cnt == PW'(POLL_CYC - 1))   poll_cnt <= '0;
    else                                      poll_cnt <= poll_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge clk_50) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (frame_start) state_nx = ST_LATCH;
      ST_LATCH:  if (latch_end)   state_nx = ST_BIT_HI;
      ST_BIT_HI: if (half_end)    state_nx = ST_BIT_LO;
      ST_BIT_LO: if (half_end)    state_nx = (bit_idx == bit_last) ? ST_DONE : ST_BIT_HI;
      ST_DONE:                    state_nx = ST_IDLE;
      default:                    state_nx = ST_IDLE;
    endcase
  end

  // Phase timer restarts on every state change; bit index advances per low phase
  always_ff @(posedge clk_50) begin
    if (reset) begin
      phase_cnt <= '0;
      bit_idx   <= '0;
      mode_q    <= 1'b0;
    end else begin
      phase_cnt <= (state_nx != state) ? '0 : phase_cnt + 1'b1;
      if (state == ST_IDLE)
        bit_idx <= '0;
      else if (state == ST_BIT_LO && state_nx == ST_BIT_HI)
        bit_idx <= bit_idx + 1'b1;
      if (frame_start) mode_q <= is_snes;
    end
  end

  // FSM output decode, taken from the next state so the pins come straight off flops
  always_comb begin
    latch_nx = (state_nx == ST_LATCH);
    clk_nx   = (state_nx != ST_BIT_LO);
    valid_nx = (state_nx == ST_DONE);
  end

  // Registered pad-facing strobes and the frame valid pulse
  always_ff @(posedge clk_50) begin
    if (reset) begin
      controller_latch <= 1'b0;
      controller_clk   <= 1'b1;
      valid            <= 1'b0;
    end else begin
      controller_latch <= latch_nx;
      controller_clk   <= clk_nx;
      valid            <= valid_nx;
    end
  end

  for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
    gamepad_pad_lane u_lane (
      .clk_50     (clk_50),
      .reset      (reset),
      .data_bit   (data[p]),
      .sample_en  (sample_en),
      .sample_idx (bit_idx),
      .commit_en  (commit_en),
      .mode_snes  (mode_q),
      .buttons    (btn_lane[p]),
      .connected  (connected[p]),
      .changed    (changed[p])
    );
  end

  assign buttons = btn_lane;

endmodule

// File: tb/tb_gamepad_multi_receiver.sv
// Bench for gamepad_multi_receiver: behavioural pad models drive the data
// lines from the latch/clock protocol; a frame-level reference model
// predicts buttons/connected/changed at each valid pulse.
module tb_gamepad_multi_receiver;

  localparam int NP = 2, HC = 4, LC = 8, PC = 400;

  logic clk_50 = 1'b0;
  logic reset;
  logic [NP-1:0] data;
  logic is_snes;
  logic controller_latch, controller_clk, valid;
  logic [NP*12-1:0] buttons;
  logic [NP-1:0] connected, changed;

  gamepad_multi_receiver #(.NUM_PADS(NP), .HALF_CYC(HC), .LATCH_CYC(LC), .POLL_CYC(PC)) dut (
    .clk_50(clk_50), .reset(reset), .data(data), .is_snes(is_snes),
    .controller_latch(controller_latch), .controller_clk(controller_clk),
    .buttons(buttons), .connected(connected), .changed(changed), .valid(valid)
  );

  always #5 clk_50 = ~clk_50;

  int checks = 0, errors = 0;
  int cyc = 0;

  // pad models: word bit k = line level during serial bit k
  logic [15:0] word [NP];
  logic [15:0] snap [NP];
  int idx [NP];
  logic prev_clk = 1'b1, prev_latch = 1'b0;
  int latch_rise_cyc = -1, latch_len = 0, lo_pulses = 0, valid_cyc = -1;
  bit frame_mode = 1'b0;
  logic [11:0] exp_prev [NP];
  logic [NP-1:0] got_changed;

  typedef struct {
    logic [15:0] w0, w1;
    bit          snes;
    logic [11:0] b0, b1;
    logic [1:0]  conn, chg;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Frame-level rules: active-low lines, all-pressed = nothing plugged in,
  // SNES needs its four trailing 1s
  function automatic logic [12:0] ref_pad(input logic [15:0] raw, input bit snes);
    int body = snes ? 12 : 8;
    int lows = 0;
    bit conn;
    logic [11:0] pr = '0;
    for (int k = 0; k < body; k++)
      if (!raw[k]) begin pr[k] = 1'b1; lows++; end
    conn = (lows < body);
    if (snes) for (int k = 12; k < 16; k++) if (!raw[k]) conn = 1'b0;
    return {conn, conn ? pr : 12'h000};
  endfunction

  // one clock: observe at negedge, advance pad models, drive data lines
  task automatic step();
    @(negedge clk_50);
    cyc++;
    if (controller_latch) begin
      for (int p = 0; p < NP; p++) begin idx[p] = 0; snap[p] = word[p]; end
    end else if (controller_clk && !prev_clk) begin
      for (int p = 0; p < NP; p++) idx[p]++;
    end
    if (controller_latch && !prev_latch) begin
      latch_rise_cyc = cyc; latch_len = 0; lo_pulses = 0; frame_mode = is_snes;
    end
    if (controller_latch) latch_len++;
    if (!controller_clk && prev_clk) lo_pulses++;
    if (valid) valid_cyc = cyc;
    prev_clk = controller_clk;
    prev_latch = controller_latch;
    for (int p = 0; p < NP; p++) data[p] = (idx[p] < 16) ? snap[p][idx[p]] : 1'b1;
  endtask

  task automatic run_frame(input string nm);
    int b = 0;
    int n;
    logic [12:0] r;
    while (!valid && b < 1000) begin step(); b++; end
    if (!valid) begin
      chk({nm, "_timeout"}, 32'd0, 32'd1);
      return;
    end
    n = frame_mode ? 16 : 8;
    chk({nm, "_latency"}, cyc - latch_rise_cyc, LC + 2 * n * HC);
    chk({nm, "_pulses"}, lo_pulses, n);
    chk({nm, "_latch_len"}, latch_len, LC);
    got_changed = changed;
    for (int p = 0; p < NP; p++) begin
      r = ref_pad(snap[p], frame_mode);
      chk($sformatf("%s_btn%0d", nm, p), buttons[p*12 +: 12], r[11:0]);
      chk($sformatf("%s_conn%0d", nm, p), connected[p], r[12]);
      chk($sformatf("%s_chg%0d", nm, p), changed[p], r[11:0] != exp_prev[p]);
      exp_prev[p] = r[11:0];
    end
    step();
    chk({nm, "_valid_pulse"}, {changed, valid}, 0);
  endtask

  task automatic wait_latch_rise(input string nm);
    int start = latch_rise_cyc;
    int b = 0;
    while (latch_rise_cyc == start && b < 1000) begin step(); b++; end
    if (latch_rise_cyc == start) chk({nm, "_latch_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int rel;
    int b;
    int lr [3];
    int vc [3];

    //        w0        w1        snes b0      b1      conn   chg
    tbl[0] = '{16'hFFFF, 16'hFFFF, 1'b0, 12'h000, 12'h000, 2'b11, 2'b00};
    tbl[1] = '{16'hFF7E, 16'hFFEF, 1'b0, 12'h081, 12'h010, 2'b11, 2'b11};
    tbl[2] = '{16'hFF7E, 16'hFFEF, 1'b0, 12'h081, 12'h010, 2'b11, 2'b00};
    tbl[3] = '{16'hFDFD, 16'hDFFF, 1'b1, 12'h202, 12'h000, 2'b01, 2'b11};
    tbl[4] = '{16'hFFFF, 16'h0000, 1'b0, 12'h000, 12'h000, 2'b01, 2'b01};
    tbl[5] = '{16'h00FF, 16'hFFFE, 1'b0, 12'h000, 12'h001, 2'b11, 2'b10};
    tbl[6] = '{16'hF000, 16'hF7FF, 1'b1, 12'h000, 12'h800, 2'b10, 2'b10};

    for (int p = 0; p < NP; p++) begin
      word[p] = 16'hFFFF; snap[p] = 16'hFFFF; idx[p] = 16; exp_prev[p] = '0;
    end
    data = '1; is_snes = 1'b0; reset = 1'b1;
    repeat (3) step();
    chk("rst_outputs", {controller_latch, controller_clk, valid, connected, changed}, 32'b0_1_0_00_00);
    chk("rst_buttons", buttons, 0);

    // table-driven frames; the first one also checks post-reset timing
    for (int i = 0; i < 7; i++) begin
      word[0] = tbl[i].w0; word[1] = tbl[i].w1; is_snes = tbl[i].snes;
      if (i == 0) begin
        reset = 1'b0; rel = cyc;
      end
      run_frame($sformatf("tbl%0d", i));
      if (i == 0) begin
        chk("first_latch_start", latch_rise_cyc - rel, 1);
        chk("first_valid_at", valid_cyc - rel, LC + 16 * 2 * HC / 2 + 1);
      end
      chk($sformatf("tbl%0d_buttons", i), buttons, {tbl[i].b1, tbl[i].b0});
      chk($sformatf("tbl%0d_connected", i), connected, tbl[i].conn);
      chk($sformatf("tbl%0d_changed", i), got_changed, tbl[i].chg);
    end

    // is_snes toggled in BIT_HI(3) must not lengthen the NES frame
    word[0] = 16'hFFBF; word[1] = 16'hFFFF; is_snes = 1'b0;
    wait_latch_rise("tog");
    b = 0;
    while (!(lo_pulses == 3 && controller_clk && !controller_latch) && b < 200) begin step(); b++; end
    is_snes = 1'b1;
    run_frame("toggle");
    chk("toggle_frame_len", lo_pulses, 8);
    is_snes = 1'b0;

    // reset in BIT_LO(5) aborts the frame at once
    word[0] = 16'hFFFE;
    wait_latch_rise("rst");
    b = 0;
    while (!(lo_pulses == 6 && !controller_clk) && b < 200) begin step(); b++; end
    chk("midrst_reached", {lo_pulses[3:0], controller_clk}, {4'd6, 1'b0});
    reset = 1'b1;
    step();
    chk("midrst_pins", {controller_latch, controller_clk, valid}, 3'b010);
    chk("midrst_outs", {buttons, connected}, 0);
    step();
    chk("midrst_hold", {valid, controller_latch}, 0);
    for (int p = 0; p < NP; p++) exp_prev[p] = '0;
    reset = 1'b0; rel = cyc;
    run_frame("after_rst");
    chk("after_rst_start", latch_rise_cyc - rel, 1);

    // randomized frames against the reference model
    for (int i = 0; i < 20; i++) begin
      for (int p = 0; p < NP; p++) begin
        case ($urandom_range(0, 3))
          0: word[p] = 16'($urandom);
          1: word[p] = {4'hF, 12'($urandom)};
          2: word[p] = 16'h0000;
          default: ;
        endcase
      end
      is_snes = 1'($urandom);
      run_frame($sformatf("rnd%0d", i));
    end

    // free-run: frame starts and commits are one poll period apart
    is_snes = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_frame($sformatf("poll%0d", i));
      lr[i] = latch_rise_cyc; vc[i] = valid_cyc;
    end
    chk("poll_latch_01", lr[1] - lr[0], PC);
    chk("poll_latch_12", lr[2] - lr[1], PC);
    chk("poll_valid_01", vc[1] - vc[0], PC);
    chk("poll_valid_12", vc[2] - vc[1], PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
